sccb_cmd_arbiter: RTL and testbench

- Shares the single SCCB/I2C write engine (i2c_sender) between two command sources:
  - the OV7670 init register ROM sequencer;
  - a runtime user register-write port, e.g. exposure/gain tweaks from board switches.
- Sits between ov7670_registers, the user control logic and i2c_sender inside the camera subsystem.
- Owns the send/taken handshake, buffers user writes in a small FIFO and guarantees init traffic precedence without starving user writes.

---
 rtl/camera_pkg.sv | 19 +
 rtl/sccb_cmd_arbiter_if.sv | 13 +
 rtl/sccb_cmd_fifo.sv | 57 +++++
 rtl/sccb_cmd_arbiter.sv | 137 +++++++++++++
 tb/tb_sccb_cmd_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_pkg.sv
// Shared definitions for the camera subsystem SCCB command path.
package camera_pkg;

    localparam int         CMD_W          = 16;
    localparam logic [7:0] CAM_ID_DEFAULT = 8'h42;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    function automatic logic [7:0] cmd_reg(input logic [CMD_W-1:0] cmd);
        return cmd[15:8];
    endfunction

    function automatic logic [7:0] cmd_value(input logic [CMD_W-1:0] cmd);
        return cmd[7:0];
    endfunction

endpackage

// File: rtl/sccb_cmd_arbiter_if.sv
// Handshake bundle between the command arbiter and the SCCB write engine.
interface sccb_cmd_arbiter_if;

    logic       i2c_send;
    logic       i2c_taken;
    logic [7:0] i2c_id;
    logic [7:0] i2c_reg;
    logic [7:0] i2c_value;

    modport master (output i2c_send, i2c_id, i2c_reg, i2c_value, input i2c_taken);
    modport slave  (input i2c_send, i2c_id, i2c_reg, i2c_value, output i2c_taken);

endinterface

// File: rtl/sccb_cmd_fifo.sv
// Synchronous FIFO for queued user register writes; pointers wrap on a power-of-two depth.
module sccb_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Shares one SCCB write engine between the init ROM sequencer and queued user writes.
// state   | meaning
// IDLE    | arbitrate between ROM and user FIFO
// GRANT   | i2c_send high, command held until i2c_taken
// HOLDOFF | gap countdown so the ROM output settles after cfg_advance
module sccb_cmd_arbiter
    import camera_pkg::*;
#(
    parameter logic [7:0] CAM_ID        = CAM_ID_DEFAULT,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         GAP_CYCLES    = 2,
    parameter int         MAX_CFG_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CMD_W-1:0]   cfg_cmd,
    input  logic               cfg_finished,
    output logic               cfg_advance,
    input  logic               usr_valid,
    input  logic [CMD_W-1:0]   usr_cmd,
    output logic               usr_ready,
    output logic               usr_overflow,
    sccb_cmd_arbiter_if.master i2c,
    output logic               grant_cfg,
    output logic               busy
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES);
    localparam int BURST_W = $clog2(MAX_CFG_BURST + 1);

    logic [1:0]         state;
    logic               send_q;
    logic [7:0]         reg_q;
    logic [7:0]         val_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic [CMD_W-1:0]   fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_push;
    logic               fifo_pop;
    logic               cfg_req;
    logic               usr_req;
    logic               taken_in_grant;

    assign cfg_req        = !cfg_finished;
    assign usr_req        = !fifo_empty;
    assign taken_in_grant = (state == ST_GRANT) && i2c.i2c_taken;

    assign usr_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_push = usr_valid && usr_ready;
    assign fifo_pop  = taken_in_grant && !grant_cfg;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    assign i2c.i2c_send  = send_q;
    assign i2c.i2c_id    = CAM_ID;
    assign i2c.i2c_reg   = reg_q;
    assign i2c.i2c_value = val_q;

    sccb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (usr_cmd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            usr_overflow <= 1'b0;
        end else if (usr_valid && fifo_full) begin
            usr_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            send_q      <= 1'b0;
            reg_q       <= '0;
            val_q       <= '0;
            grant_cfg   <= 1'b0;
            cfg_advance <= 1'b0;
            gap_cnt     <= '0;
            burst_cnt   <= '0;
        end else begin
            cfg_advance <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // ROM wins unless it has already used its burst allowance while users wait
                    if (cfg_req && (!usr_req || burst_cnt < BURST_W'(MAX_CFG_BURST))) begin
                        reg_q     <= cmd_reg(cfg_cmd);
                        val_q     <= cmd_value(cfg_cmd);
                        grant_cfg <= 1'b1;
                        burst_cnt <= usr_req ? burst_cnt + 1'b1 : '0;
                        send_q    <= 1'b1;
                        state     <= ST_GRANT;
                    end else if (usr_req) begin
                        reg_q     <= cmd_reg(fifo_head);
                        val_q     <= cmd_value(fifo_head);
                        grant_cfg <= 1'b0;
                        burst_cnt <= '0;
                        send_q    <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (i2c.i2c_taken) begin
                        send_q      <= 1'b0;
                        cfg_advance <= grant_cfg;
                        gap_cnt     <= GAP_W'(GAP_CYCLES - 1);
                        state       <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Scoreboard bench for sccb_cmd_arbiter: ROM and user sources against a scripted SCCB sender.
module tb_sccb_cmd_arbiter;
    import camera_pkg::*;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_cmd;
    logic        cfg_finished;
    logic        cfg_advance;
    logic        usr_valid = 1'b0;
    logic [15:0] usr_cmd = 16'h0000;
    logic        usr_ready;
    logic        usr_overflow;
    logic        grant_cfg;
    logic        busy;

    sccb_cmd_arbiter_if i2c ();

    logic [15:0] rom_data [32];
    int          rom_len = 0;
    int          rom_addr;
    int          adv_cnt;
    logic [16:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sccb_cmd_arbiter #(
        .CAM_ID        (8'h42),
        .FIFO_DEPTH    (4),
        .GAP_CYCLES    (GAP),
        .MAX_CFG_BURST (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_cmd      (cfg_cmd),
        .cfg_finished (cfg_finished),
        .cfg_advance  (cfg_advance),
        .usr_valid    (usr_valid),
        .usr_cmd      (usr_cmd),
        .usr_ready    (usr_ready),
        .usr_overflow (usr_overflow),
        .i2c          (i2c),
        .grant_cfg    (grant_cfg),
        .busy         (busy)
    );

    // ROM model: address steps on cfg_advance, new command visible the next cycle
    assign cfg_cmd      = (rom_addr < 32) ? rom_data[rom_addr] : 16'h0000;
    assign cfg_finished = (rom_addr >= rom_len);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= 0;
            adv_cnt  <= 0;
        end else if (cfg_advance) begin
            rom_addr <= rom_addr + 1;
            adv_cnt  <= adv_cnt + 1;
        end
    end

    task automatic do_reset(input int len);
        rst = 1'b1;
        usr_valid = 1'b0;
        i2c.i2c_taken = 1'b0;
        rom_len = len;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] c, input logic enq);
        usr_valid = 1'b1;
        usr_cmd = c;
        if (enq) exp_q.push_back({1'b0, c});
        @(negedge clk);
        usr_valid = 1'b0;
    endtask

    // sender model: wait for send, hold dly cycles, pulse taken, report what was on the bus
    task automatic serve(input int dly, output logic [16:0] obs, output logic adv,
                         output int low, output logic to);
        to = 1'b0;
        low = 0;
        obs = '0;
        adv = 1'b0;
        while (i2c.i2c_send !== 1'b1) begin
            if (low > 100) begin
                to = 1'b1;
                return;
            end
            @(negedge clk);
            low++;
        end
        repeat (dly) @(negedge clk);
        obs = {grant_cfg, i2c.i2c_reg, i2c.i2c_value};
        i2c.i2c_taken = 1'b1;
        @(negedge clk);
        i2c.i2c_taken = 1'b0;
        adv = cfg_advance;
    endtask

    task automatic test_reset();
        int w;
        do_reset(0);
        n_tests++;
        if (i2c.i2c_send !== 1'b0 || cfg_advance !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: send=%b adv=%b, want 0 0", i2c.i2c_send, cfg_advance);
        end
        n_tests++;
        if ({i2c.i2c_reg, i2c.i2c_value} !== 16'h0000 || i2c.i2c_id !== 8'h42) begin
            n_fail++;
            $display("FAIL reset_bus: reg/val=%h id=%h, want 0000 42",
                     {i2c.i2c_reg, i2c.i2c_value}, i2c.i2c_id);
        end
        n_tests++;
        if ({grant_cfg, busy, usr_overflow, usr_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_status: gcfg/busy/ovf/ready=%b, want 0001",
                     {grant_cfg, busy, usr_overflow, usr_ready});
        end
        do_push(16'h1234, 1'b0);
        w = 0;
        while (i2c.i2c_send !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (i2c.i2c_send !== 1'b1 || {i2c.i2c_reg, i2c.i2c_value} !== 16'h1234) begin
            n_fail++;
            $display("FAIL reset_pre_grant: send=%b cmd=%h, want 1 1234",
                     i2c.i2c_send, {i2c.i2c_reg, i2c.i2c_value});
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({i2c.i2c_send, usr_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_async: send/ready/busy=%b, want 010",
                     {i2c.i2c_send, usr_ready, busy});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cfg_seq();
        logic [16:0] obs, exp;
        logic        adv, to;
        int          low;
        rom_data[0] = 16'h1280;
        rom_data[1] = 16'h1101;
        rom_data[2] = 16'h0C00;
        do_reset(3);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, rom_data[i]});
        for (int i = 0; i < 3; i++) begin
            serve(5, obs, adv, low, to);
            exp = exp_q.pop_front();
            n_tests++;
            if (to || obs !== exp) begin
                n_fail++;
                $display("FAIL cfg_seq_cmd%0d: got %h timeout=%0b, want %h", i, obs, to, exp);
            end
            n_tests++;
            if (adv !== 1'b1 || i2c.i2c_send !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_seq_adv%0d: adv=%b send=%b, want 1 0", i, adv, i2c.i2c_send);
            end
            if (i > 0) begin
                n_tests++;
                if (low < GAP) begin
                    n_fail++;
                    $display("FAIL cfg_seq_gap%0d: send low %0d cycles, want >= %0d", i, low, GAP);
                end
            end
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (adv_cnt !== 3 || i2c.i2c_send !== 1'b0 || busy !== 1'b0 || cfg_finished !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_seq_end: adv_cnt=%0d send=%b busy=%b fin=%b, want 3 0 0 1",
                     adv_cnt, i2c.i2c_send, busy, cfg_finished);
        end
    endtask

    task automatic test_usr_b2b();
        logic [16:0] obs, exp;
        logic        adv, to;
        int          low, w;
        do_reset(0);
        do_push(16'h1040, 1'b1);
        do_push(16'h00FF, 1'b1);
        for (int i = 0; i < 2; i++) begin
            serve(3, obs, adv, low, to);
            exp = exp_q.pop_front();
            n_tests++;
            if (to || obs !== exp || adv !== 1'b0) begin
                n_fail++;
                $display("FAIL usr_b2b_cmd%0d: got %h adv=%b timeout=%0b, want %h adv=0",
                         i, obs, adv, to, exp);
            end
        end
        n_tests++;
        if (busy !== 1'b1 || usr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL usr_b2b_holdoff: busy=%b ready=%b, want 1 1", busy, usr_ready);
        end
        w = 0;
        while (busy !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (busy !== 1'b0 || w > GAP + 1) begin
            n_fail++;
            $display("FAIL usr_b2b_idle: busy=%b after %0d cycles, want 0 within %0d", busy, w, GAP + 1);
        end
    endtask

    task automatic test_burst();
        logic [16:0] obs, exp;
        logic        adv, to;
        int          low, errs;
        for (int i = 0; i < 20; i++) rom_data[i] = {8'(8'h20 + i), 8'(8'hA0 + i)};
        do_reset(0);
        exp_q.push_back({1'b0, 16'h3A01});
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, rom_data[i]});
        exp_q.push_back({1'b0, 16'h3B02});
        for (int i = 8; i < 20; i++) exp_q.push_back({1'b1, rom_data[i]});
        do_push(16'h3A01, 1'b0);
        do_push(16'h3B02, 1'b0);
        n_tests++;
        if (i2c.i2c_send !== 1'b1 || grant_cfg !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_usr_first: send=%b gcfg=%b, want 1 0", i2c.i2c_send, grant_cfg);
        end
        rom_len = 20;
        errs = 0;
        for (int i = 0; i < 22; i++) begin
            serve(2, obs, adv, low, to);
            exp = exp_q.pop_front();
            n_tests++;
            if (to || obs !== exp || adv !== exp[16]) begin
                n_fail++;
                errs++;
                $display("FAIL burst_grant%0d: got %h adv=%b timeout=%0b, want %h adv=%b",
                         i, obs, adv, to, exp, exp[16]);
                if (to) break;
            end
        end
        repeat (8) @(negedge clk);
        n_tests++;
        if (adv_cnt !== 20 || cfg_finished !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: adv_cnt=%0d fin=%b busy=%b, want 20 1 0", adv_cnt, cfg_finished, busy);
        end
    endtask

    task automatic test_overflow();
        logic [16:0] obs, exp;
        logic        adv, to;
        int          low;
        do_reset(0);
        for (int i = 0; i < 4; i++) do_push(16'h5000 + 16'(i), 1'b1);
        n_tests++;
        if (usr_ready !== 1'b0 || usr_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: ready=%b ovf=%b, want 0 0", usr_ready, usr_overflow);
        end
        do_push(16'h5EEE, 1'b0);
        repeat (4) @(negedge clk);
        n_tests++;
        if (usr_overflow !== 1'b1 || usr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf=%b ready=%b, want 1 0", usr_overflow, usr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            serve(1, obs, adv, low, to);
            exp = exp_q.pop_front();
            n_tests++;
            if (to || obs !== exp) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got %h timeout=%0b, want %h", i, obs, to, exp);
            end
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if ({usr_ready, usr_overflow, busy, i2c.i2c_send} !== 4'b1100) begin
            n_fail++;
            $display("FAIL ovf_after: ready/ovf/busy/send=%b, want 1100",
                     {usr_ready, usr_overflow, busy, i2c.i2c_send});
        end
    endtask

    task automatic test_taken_ignored();
        logic [16:0] obs, exp;
        logic        adv, to;
        int          low;
        do_reset(0);
        i2c.i2c_taken = 1'b1;
        @(negedge clk);
        i2c.i2c_taken = 1'b0;
        @(negedge clk);
        n_tests++;
        if (adv_cnt !== 0 || {busy, i2c.i2c_send, usr_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL taken_idle: adv_cnt=%0d busy/send/ready=%b, want 0 001",
                     adv_cnt, {busy, i2c.i2c_send, usr_ready});
        end
        do_push(16'h6A11, 1'b1);
        do_push(16'h6B22, 1'b1);
        serve(2, obs, adv, low, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || obs !== exp) begin
            n_fail++;
            $display("FAIL taken_first: got %h timeout=%0b, want %h", obs, to, exp);
        end
        i2c.i2c_taken = 1'b1;
        @(negedge clk);
        i2c.i2c_taken = 1'b0;
        n_tests++;
        if (i2c.i2c_send !== 1'b0 || busy !== 1'b1 || cfg_advance !== 1'b0) begin
            n_fail++;
            $display("FAIL taken_holdoff: send=%b busy=%b adv=%b, want 0 1 0",
                     i2c.i2c_send, busy, cfg_advance);
        end
        serve(2, obs, adv, low, to);
        exp = exp_q.pop_front();
        n_tests++;
        if (to || obs !== exp || adv_cnt !== 0) begin
            n_fail++;
            $display("FAIL taken_second: got %h timeout=%0b adv_cnt=%0d, want %h 0", obs, to, adv_cnt, exp);
        end
    endtask

    initial begin
        i2c.i2c_taken = 1'b0;
        for (int i = 0; i < 32; i++) rom_data[i] = 16'h0000;
        test_reset();
        test_cfg_seq();
        test_usr_b2b();
        test_burst();
        test_overflow();
        test_taken_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
